dram_arb: RTL
=============

DRAM_ARB -- requirements
Module: dram_arb

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DATA_WIDTH, 32, DRAM word width.
- ADDR_WIDTH, 18, DRAM word address width.
- NUM_REQ, 3, requester count; 0=conv, 1=relu, 2=pool.
- MAX_BURST, 16, maximum consecutive grants to one requester while others wait.
- TIMEOUT, 1024, maximum read-wait cycles before abort.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic on rising edge.
- srst, in, 1, synchronous active-high reset.
- req, in, NUM_REQ, per-requester access request; held until granted.
- we, in, NUM_REQ, per-requester write flag: 1=write, 0=read.
- addr, in, NUM_REQ*ADDR_WIDTH, per-requester address; requester k occupies slice k.
- wdata, in, NUM_REQ*DATA_WIDTH, per-requester write data; requester k occupies slice k.
- gnt, out, NUM_REQ, one-hot combinational accept pulse.
- rvalid, out, NUM_REQ, one-hot read-return pulse.
- rdata, out, DATA_WIDTH, read-return data, shared by all requesters.
- dram_en_wr, out, 1, DRAM write enable.
- dram_addr_wr, out, ADDR_WIDTH, DRAM write address.
- dram_data_wr, out, DATA_WIDTH, DRAM write data.
- dram_en_rd, out, 1, DRAM read enable.
- dram_addr_rd, out, ADDR_WIDTH, DRAM read address.
- dram_valid, in, 1, DRAM read data valid.
- dram_data_rd, in, DATA_WIDTH, DRAM read data.
- busy, out, 1, high when not in IDLE.
- err, out, 1, sticky read-timeout flag.

REQ-003 Only one clock and one reset exist; srst is synchronous and active-high.

Function
REQ-004 FSM states: IDLE, RD_WAIT, RD_RET.

REQ-005 IDLE: if any req is high, exactly one gnt bit rises in the same cycle; otherwise gnt is all zero.

REQ-006 Winner selection is round-robin, searching upward from rr_ptr and wrapping from NUM_REQ-1 to 0.

REQ-007 Pointer update after a grant to requester k:
- If burst_cnt < MAX_BURST-1: rr_ptr stays k and burst_cnt increments.
- Otherwise: rr_ptr becomes (k+1) mod NUM_REQ and burst_cnt clears.
- Any grant to a requester other than the previous owner clears burst_cnt to 1.

REQ-008 Granted write at cycle t:
- dram_en_wr=1 at cycle t+1 only, with registered addr/wdata slice k.
- State remains IDLE, so back-to-back writes sustain one per cycle.

REQ-009 Granted read at cycle t:
- dram_en_rd=1 at cycle t+1 only, with dram_addr_rd = addr slice k.
- State becomes RD_WAIT at t+1; owner index latched.

REQ-010 RD_WAIT behaviour:
- gnt is all zero, including the dram_valid cycle.
- On dram_valid, latch dram_data_rd and go to RD_RET.

REQ-011 RD_RET lasts one cycle:
- rvalid[owner]=1 and rdata=latched data.
- State returns to IDLE; a new gnt is permitted in that same RD_RET cycle's successor only, i.e. RD_RET grants nothing.

REQ-012 Read latency: dram_valid at cycle v gives rvalid at v+1.

REQ-013 Read timeout:
- The wait counter starts at 0 on RD_WAIT entry.
- If TIMEOUT cycles elapse without dram_valid: err=1 (sticky until srst), then RD_RET with rdata=0.

REQ-014 dram_valid outside RD_WAIT is ignored and has no effect on any state.

REQ-015 A req bit deasserted before grant is legal; that requester is dropped from arbitration.

REQ-016 dram_en_wr and dram_en_rd are never high in the same cycle.

REQ-017 rdata holds its last value when rvalid is low.

Reset
REQ-018 srst high at a clock edge gives the following reset values:
- State=IDLE, rr_ptr=0, burst_cnt=0, wait counter=0, err=0.
- gnt, rvalid, dram_en_wr, dram_en_rd, busy all 0.
- All address/data outputs and rdata = 0.

REQ-019 srst during RD_WAIT abandons the read with no rvalid; a later dram_valid is ignored.

REQ-020 gnt is forced to 0 while srst is high.

Verification
REQ-021 Single write: req=001, we=001, addr0=0x00100, wdata0=0xDEADBEEF -> gnt=001 same cycle; next cycle dram_en_wr=1, dram_addr_wr=0x00100, dram_data_wr=0xDEADBEEF.

REQ-022 Read: req=010 read at addr 0x10000; DRAM returns 0x12345678 three cycles after dram_en_rd -> rvalid=010 and rdata=0x12345678 one cycle after dram_valid; no gnt during wait.

REQ-023 Fairness: req=111 writes held continuously, MAX_BURST=16 -> gnt sequence is 16x001, 16x010, 16x100, then repeats; no gaps in dram_en_wr.

REQ-024 Timeout: read issued, dram_valid never asserted -> after 1024 wait cycles err=1, rvalid=owner with rdata=0; err stays 1 until srst.

REQ-025 Reset mid-read: srst pulsed in RD_WAIT, then dram_valid arrives -> no rvalid, busy=0, next req granted normally starting from requester 0.

Source files
------------

// File: rtl/dram_arb.sv
// dram_arb: round-robin arbiter sharing one DRAM read/write port among
// NUM_REQ requesters, with burst limiting and a read-wait timeout.
module dram_arb #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 18,
   parameter int NUM_REQ    = 3,
   parameter int MAX_BURST  = 16,
   parameter int TIMEOUT    = 1024
) (
   input  logic                          clk,
   input  logic                          srst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ-1:0]            we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
   output logic [NUM_REQ-1:0]            gnt,
   output logic [NUM_REQ-1:0]            rvalid,
   output logic [DATA_WIDTH-1:0]         rdata,
   output logic                          dram_en_wr,
   output logic [ADDR_WIDTH-1:0]         dram_addr_wr,
   output logic [DATA_WIDTH-1:0]         dram_data_wr,
   output logic                          dram_en_rd,
   output logic [ADDR_WIDTH-1:0]         dram_addr_rd,
   input  logic                          dram_valid,
   input  logic [DATA_WIDTH-1:0]         dram_data_rd,
   output logic                          busy,
   output logic                          err
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int BW = $clog2(MAX_BURST + 1);
   localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, RD_WAIT, RD_RET} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   rr_ptr, prev_owner, owner, win, ptr_nxt;
   logic [BW-1:0]   burst_cnt, eff_cnt, cnt_nxt;
   logic [WW-1:0]   wait_cnt;
   logic            any_req, take, rd_timeout;

   // Round-robin search upward from rr_ptr, wrapping at NUM_REQ-1.
   always_comb begin
      int unsigned j;
      any_req = 1'b0;
      win     = '0;
      j       = 0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         j = (32'(rr_ptr) + i) % NUM_REQ;
         if (!any_req && req[j]) begin
            any_req = 1'b1;
            win     = IW'(j);
         end
      end
   end

   // Burst accounting: a new owner restarts the run, so its count is taken as zero.
   always_comb begin
      eff_cnt = (win == prev_owner) ? burst_cnt : '0;
      if (32'(eff_cnt) < MAX_BURST - 1) begin
         ptr_nxt = win;
         cnt_nxt = eff_cnt + 1'b1;
      end else begin
         ptr_nxt = (32'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
         cnt_nxt = '0;
      end
   end

   // Next-state and combinational grant/busy outputs.
   always_comb begin
      state_d    = state_q;
      gnt        = '0;
      take       = 1'b0;
      rd_timeout = (32'(wait_cnt) == TIMEOUT - 1);
      busy       = (state_q != IDLE);
      case (state_q)
         IDLE: begin
            if (any_req && !srst) begin
               take     = 1'b1;
               gnt[win] = 1'b1;
               if (!we[win]) state_d = RD_WAIT;
            end
         end
         RD_WAIT: if (dram_valid || rd_timeout) state_d = RD_RET;
         RD_RET:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (srst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Arbitration bookkeeping, DRAM command registers and read return path.
   always_ff @(posedge clk) begin
      if (srst) begin
         rr_ptr       <= '0;
         prev_owner   <= '0;
         owner        <= '0;
         burst_cnt    <= '0;
         wait_cnt     <= '0;
         err          <= 1'b0;
         rvalid       <= '0;
         rdata        <= '0;
         dram_en_wr   <= 1'b0;
         dram_addr_wr <= '0;
         dram_data_wr <= '0;
         dram_en_rd   <= 1'b0;
         dram_addr_rd <= '0;
      end else begin
         dram_en_wr <= 1'b0;
         dram_en_rd <= 1'b0;
         rvalid     <= '0;
         if (take) begin
            rr_ptr     <= ptr_nxt;
            burst_cnt  <= cnt_nxt;
            prev_owner <= win;
            owner      <= win;
            if (we[win]) begin
               dram_en_wr   <= 1'b1;
               dram_addr_wr <= addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
               dram_data_wr <= wdata[int'(win)*DATA_WIDTH +: DATA_WIDTH];
            end else begin
               dram_en_rd   <= 1'b1;
               dram_addr_rd <= addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
               wait_cnt     <= '0;
            end
         end
         if (state_q == RD_WAIT) begin
            if (dram_valid) begin
               rdata         <= dram_data_rd;
               rvalid[owner] <= 1'b1;
            end else if (rd_timeout) begin
               rdata         <= '0;
               err           <= 1'b1;
               rvalid[owner] <= 1'b1;
            end else begin
               wait_cnt <= wait_cnt + 1'b1;
            end
         end
      end
   end

endmodule
